// File: rtl/decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_queue                                                               |
// | Decodes RV32I(+M) instructions as fetch offers them and holds the decoded  |
// | records in a small FIFO in front of the consumer.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int EN_M  = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [XLEN-1:0]        out_imm,
  output logic [2:0]             out_funct3,
  output logic                   out_alt,
  output logic [3:0]             out_class,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [3:0] CLS_RALU   = 4'd0;
  localparam logic [3:0] CLS_IALU   = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_MULDIV = 4'd9;
  localparam logic [3:0] CLS_SYSTEM = 4'd10;
  localparam logic [3:0] CLS_FENCE  = 4'd11;
  localparam logic [3:0] CLS_ILL    = 4'd15;

  typedef enum logic [2:0] {FMT_N, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic            alt;
    logic [3:0]      cls;
    logic            illegal;
  } rec_t;

  logic [6:0]      dec_opc;
  logic [2:0]      dec_f3;
  logic [6:0]      dec_f7;
  logic [6:0]      dec_f7_sh;
  fmt_e            dec_fmt;
  logic [3:0]      dec_cls;
  logic [4:0]      dec_rd;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [XLEN-1:0] dec_imm;
  rec_t            dec_rec;
  rec_t            head;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  assign dec_opc = in_instr[6:0];
  assign dec_f3  = in_instr[14:12];
  assign dec_f7  = in_instr[31:25];
  // RV64 shift amounts borrow instr[25], so only the upper six bits qualify the shift kind.
  assign dec_f7_sh = (XLEN == 64) ? {in_instr[31:26], 1'b0} : in_instr[31:25];

  // Classify the opcode, pick its operand format and apply the legality rules.
  always_comb begin
    dec_fmt = FMT_N;
    dec_cls = CLS_ILL;
    case (dec_opc)
      OPC_OP: begin
        dec_fmt = FMT_R;
        if (dec_f7 == 7'b0000000)
          dec_cls = CLS_RALU;
        else if (dec_f7 == 7'b0100000 && (dec_f3 == 3'b000 || dec_f3 == 3'b101))
          dec_cls = CLS_RALU;
        else if (dec_f7 == 7'b0000001 && EN_M != 0)
          dec_cls = CLS_MULDIV;
      end
      OPC_IMM: begin
        dec_fmt = FMT_I;
        if (dec_f3 == 3'b001)
          dec_cls = (dec_f7_sh == 7'b0000000) ? CLS_IALU : CLS_ILL;
        else if (dec_f3 == 3'b101)
          dec_cls = (dec_f7_sh == 7'b0000000 || dec_f7_sh == 7'b0100000) ? CLS_IALU : CLS_ILL;
        else
          dec_cls = CLS_IALU;
      end
      OPC_LOAD: begin
        dec_fmt = FMT_I;
        dec_cls = (dec_f3 == 3'b011 || dec_f3 == 3'b110 || dec_f3 == 3'b111) ? CLS_ILL : CLS_LOAD;
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        dec_cls = (dec_f3 >= 3'b011) ? CLS_ILL : CLS_STORE;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        dec_cls = (dec_f3 == 3'b010 || dec_f3 == 3'b011) ? CLS_ILL : CLS_BRANCH;
      end
      OPC_JAL:    begin dec_fmt = FMT_J; dec_cls = CLS_JAL;    end
      OPC_JALR:   begin dec_fmt = FMT_I; dec_cls = CLS_JALR;   end
      OPC_LUI:    begin dec_fmt = FMT_U; dec_cls = CLS_LUI;    end
      OPC_AUIPC:  begin dec_fmt = FMT_U; dec_cls = CLS_AUIPC;  end
      OPC_SYSTEM: begin dec_fmt = FMT_I; dec_cls = CLS_SYSTEM; end
      OPC_FENCE:  begin dec_fmt = FMT_I; dec_cls = CLS_FENCE;  end
      default: ;
    endcase
  end

  // Extract register fields and the sign-extended immediate for the chosen format.
  always_comb begin
    dec_rd  = '0;
    dec_rs1 = '0;
    dec_rs2 = '0;
    dec_imm = '0;
    case (dec_fmt)
      FMT_R: begin
        dec_rd  = in_instr[11:7];
        dec_rs1 = in_instr[19:15];
        dec_rs2 = in_instr[24:20];
      end
      FMT_I: begin
        dec_rd  = in_instr[11:7];
        dec_rs1 = in_instr[19:15];
        dec_imm = XLEN'($signed(in_instr[31:20]));
      end
      FMT_S: begin
        dec_rs1 = in_instr[19:15];
        dec_rs2 = in_instr[24:20];
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      FMT_B: begin
        dec_rs1 = in_instr[19:15];
        dec_rs2 = in_instr[24:20];
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
      end
      FMT_U: begin
        dec_rd  = in_instr[11:7];
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      FMT_J: begin
        dec_rd  = in_instr[11:7];
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
      end
      default: ;
    endcase
  end

  assign dec_rec = '{pc: in_pc, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, imm: dec_imm,
                     funct3: dec_f3, alt: in_instr[30], cls: dec_cls,
                     illegal: (dec_cls == CLS_ILL)};

  assign in_ready  = (count_q < DEPTH_C);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Pointer and occupancy update; flush wins over any push or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)
        count_d = count_q + CNT_W'(1);
      else if (pop && !push)
        count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; stale contents are never visible because the head is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_rec;
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc      = head.pc;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_imm     = head.imm;
  assign out_funct3  = head.funct3;
  assign out_alt     = head.alt;
  assign out_class   = head.cls;
  assign out_illegal = head.illegal;
  assign count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_decode_queue                                                            |
// | Self-checking bench for decode_queue (EN_M=1 and EN_M=0 instances).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn, in_valid, flush, out_ready;
  logic [31:0] in_pc, in_instr;

  logic        m_in_ready, m_out_valid, m_alt, m_ill;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [2:0]  m_f3;
  logic [3:0]  m_cls;
  logic [2:0]  m_count;

  logic        n_in_ready, n_out_valid, n_alt, n_ill;
  logic [31:0] n_pc, n_imm;
  logic [4:0]  n_rd, n_rs1, n_rs2;
  logic [2:0]  n_f3;
  logic [3:0]  n_cls;
  logic [2:0]  n_count;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_M(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_pc(m_pc),
    .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2), .out_imm(m_imm),
    .out_funct3(m_f3), .out_alt(m_alt), .out_class(m_cls),
    .out_illegal(m_ill), .count(m_count));

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .EN_M(0)) dut_nm (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_pc),
    .out_rd(n_rd), .out_rs1(n_rs1), .out_rs2(n_rs2), .out_imm(n_imm),
    .out_funct3(n_f3), .out_alt(n_alt), .out_class(n_cls),
    .out_illegal(n_ill), .count(n_count));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        alt;
    logic [3:0]  cls;
    logic        ill;
  } dec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t mq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference decoder: instruction-set rules written out directly.
  function automatic dec_t ref_dec(logic [31:0] pc, logic [31:0] ins, bit en_m);
    dec_t       d;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    byte        fmt;
    int         cls;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    d = '0; d.pc = pc; d.f3 = f3; d.alt = ins[30];
    fmt = "N"; cls = 15;
    case (op)
      7'h33: begin
        fmt = "R";
        if (f7 == 7'h00) cls = 0;
        else if (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) cls = 0;
        else if (f7 == 7'h01 && en_m) cls = 9;
      end
      7'h13: begin
        fmt = "I"; cls = 1;
        if (f3 == 3'd1 && f7 != 7'h00) cls = 15;
        if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) cls = 15;
      end
      7'h03: begin fmt = "I"; cls = (f3 inside {3'd3, 3'd6, 3'd7}) ? 15 : 2; end
      7'h23: begin fmt = "S"; cls = (f3 >= 3'd3) ? 15 : 3; end
      7'h63: begin fmt = "B"; cls = (f3 inside {3'd2, 3'd3}) ? 15 : 4; end
      7'h6f: begin fmt = "J"; cls = 5; end
      7'h67: begin fmt = "I"; cls = 6; end
      7'h37: begin fmt = "U"; cls = 7; end
      7'h17: begin fmt = "U"; cls = 8; end
      7'h73: begin fmt = "I"; cls = 10; end
      7'h0f: begin fmt = "I"; cls = 11; end
      default: ;
    endcase
    if (fmt inside {"R", "I", "U", "J"}) d.rd  = ins[11:7];
    if (fmt inside {"R", "I", "S", "B"}) d.rs1 = ins[19:15];
    if (fmt inside {"R", "S", "B"})      d.rs2 = ins[24:20];
    case (fmt)
      "I": d.imm = 32'($signed(ins) >>> 20);
      "S": d.imm = (32'($signed(ins) >>> 20) & 32'hFFFF_FFE0) | {27'b0, ins[11:7]};
      "B": d.imm = ({32{ins[31]}} << 12) | ({31'b0, ins[7]} << 11) |
                   ({26'b0, ins[30:25]} << 5) | ({28'b0, ins[11:8]} << 1);
      "U": d.imm = ins & 32'hFFFF_F000;
      "J": d.imm = ({32{ins[31]}} << 20) | ({24'b0, ins[19:12]} << 12) |
                   ({31'b0, ins[20]} << 11) | ({22'b0, ins[30:21]} << 1);
      default: d.imm = '0;
    endcase
    d.cls = 4'(cls);
    d.ill = (cls == 15);
    return d;
  endfunction

  // Operand fields of an illegal entry carry no meaning; keep only pc/class/flag.
  function automatic dec_t msk(dec_t d, logic ill);
    dec_t r;
    r = d;
    if (ill) begin
      r.rd = '0; r.rs1 = '0; r.rs2 = '0; r.imm = '0; r.f3 = '0; r.alt = 1'b0;
    end
    return r;
  endfunction

  function automatic dec_t obs_m();
    return '{pc: m_pc, rd: m_rd, rs1: m_rs1, rs2: m_rs2, imm: m_imm,
             f3: m_f3, alt: m_alt, cls: m_cls, ill: m_ill};
  endfunction

  function automatic dec_t obs_n();
    return '{pc: n_pc, rd: n_rd, rs1: n_rs1, rs2: n_rs2, imm: n_imm,
             f3: n_f3, alt: n_alt, cls: n_cls, ill: n_ill};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 11))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h6f;  6: op = 7'h67;  7: op = 7'h37;
      8: op = 7'h17;  9: op = 7'h73;  10: op = 7'h0f;
      default: op = 7'($urandom());
    endcase
    r[6:0] = op;
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  // Advance one clock and apply the same edge to the reference queue.
  task automatic tick();
    bit   push, pop;
    ent_t e;
    @(posedge clk);
    push = in_valid && (mq.size() < DEPTH) && !flush;
    pop  = out_ready && (mq.size() != 0) && !flush;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin e.pc = in_pc; e.ins = in_instr; mq.push_back(e); end
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #12;
    total++;
    if (obs_m() !== '0 || m_out_valid !== 1'b0 || m_count !== 3'd0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: fields=%h valid=%b count=%0d ready=%b want all zero, ready=1",
               obs_m(), m_out_valid, m_count, m_in_ready);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    dec_t ex;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hFFF00093;
    tick();
    in_valid = 1'b0;
    ex = '{pc: 32'h100, rd: 5'd1, rs1: 5'd0, rs2: 5'd0, imm: 32'hFFFF_FFFF,
           f3: 3'd0, alt: 1'b1, cls: 4'd1, ill: 1'b0};
    total++;
    if (m_out_valid !== 1'b1 || obs_m() !== ex) begin
      bad++;
      $display("FAIL addi_decode: valid=%b got %h want %h", m_out_valid, obs_m(), ex);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (m_count !== 3'd0 || m_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL addi_pop: count=%0d valid=%b want 0/0", m_count, m_out_valid);
    end
  endtask

  task automatic test_fill();
    logic [31:0] ins [6];
    dec_t        first, ex;
    ins = '{32'h00500113, 32'h00C0A183, 32'h00312423, 32'hFE208EE3, 32'h123450B7, 32'h0000006F};
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(4 * i); in_instr = ins[i];
      tick();
      if (i == 0) first = obs_m();
      total++;
      if (m_count !== 3'((i + 1 > 4) ? 4 : i + 1) || m_in_ready !== (i + 1 < 4)) begin
        bad++;
        $display("FAIL fill_step%0d: count=%0d ready=%b want %0d/%b", i, m_count, m_in_ready,
                 (i + 1 > 4) ? 4 : i + 1, (i + 1 < 4));
      end
      total++;
      if (obs_m() !== first) begin
        bad++;
        $display("FAIL fill_hold%0d: got %h want %h", i, obs_m(), first);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ex = ref_dec(32'h1000 + 32'(4 * k), ins[k], 1'b1);
      total++;
      if (m_out_valid !== 1'b1 || msk(obs_m(), ex.ill) !== msk(ex, ex.ill)) begin
        bad++;
        $display("FAIL fill_pop%0d: valid=%b got %h want %h", k, m_out_valid, obs_m(), ex);
      end
      tick();
    end
    out_ready = 1'b0;
    total++;
    if (m_out_valid !== 1'b0 || m_count !== 3'd0) begin
      bad++;
      $display("FAIL fill_drained: valid=%b count=%0d want 0/0", m_out_valid, m_count);
    end
  endtask

  task automatic test_muldiv();
    in_valid = 1'b1; in_pc = 32'h200; in_instr = 32'h022081B3;
    tick();
    in_pc = 32'h204; in_instr = 32'h402081B3;
    tick();
    in_pc = 32'h208; in_instr = 32'h402091B3;
    tick();
    in_valid = 1'b0;
    total++;
    if (m_cls !== 4'd9 || m_ill !== 1'b0 || m_rd !== 5'd3) begin
      bad++;
      $display("FAIL mul_en_m: class=%0d ill=%b rd=%0d want 9/0/3", m_cls, m_ill, m_rd);
    end
    total++;
    if (n_cls !== 4'd15 || n_ill !== 1'b1) begin
      bad++;
      $display("FAIL mul_no_m: class=%0d ill=%b want 15/1", n_cls, n_ill);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (m_cls !== 4'd0 || m_alt !== 1'b1 || n_cls !== 4'd0 || n_alt !== 1'b1) begin
      bad++;
      $display("FAIL sub_decode: class=%0d/%0d alt=%b/%b want 0/0 1/1", m_cls, n_cls, m_alt, n_alt);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (m_cls !== 4'd15 || m_ill !== 1'b1 || m_pc !== 32'h208) begin
      bad++;
      $display("FAIL bad_funct7: class=%0d ill=%b pc=%h want 15/1/208", m_cls, m_ill, m_pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    dec_t ex;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h400 + 32'(4 * i); in_instr = gen_instr();
      tick();
    end
    total++;
    if (m_count !== 3'd3) begin
      bad++;
      $display("FAIL flush_preload: count=%0d want 3", m_count);
    end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4FC; in_instr = 32'h00100093; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    total++;
    if (m_count !== 3'd0 || m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear: count=%0d valid=%b ready=%b want 0/0/1", m_count, m_out_valid, m_in_ready);
    end
    tick();
    total++;
    if (m_count !== 3'd0 || m_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_push_dropped: count=%0d valid=%b want 0/0", m_count, m_out_valid);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'h00700393;
    tick();
    in_valid = 1'b0;
    ex = ref_dec(32'h300, 32'h00700393, 1'b1);
    total++;
    if (m_count !== 3'd1 || obs_m() !== ex) begin
      bad++;
      $display("FAIL push_after_flush: count=%0d got %h want 1 %h", m_count, obs_m(), ex);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    dec_t ex;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h500 + 32'(4 * i); in_instr = 32'h00A00513;
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (m_count !== 3'd2) begin
      bad++;
      $display("FAIL pre_reset_count: count=%0d want 2", m_count);
    end
    #2;
    rstn = 1'b0;
    mq.delete();
    #1;
    total++;
    if (obs_m() !== '0 || m_out_valid !== 1'b0 || m_count !== 3'd0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: fields=%h valid=%b count=%0d ready=%b want zeros, ready=1",
               obs_m(), m_out_valid, m_count, m_in_ready);
    end
    #3;
    rstn = 1'b1;
    in_valid = 1'b1; in_pc = 32'h600; in_instr = 32'h00000037;
    tick();
    in_valid = 1'b0;
    ex = ref_dec(32'h600, 32'h00000037, 1'b1);
    total++;
    if (m_out_valid !== 1'b1 || m_cls !== 4'd7 || m_imm !== 32'd0 || m_rd !== 5'd0 || obs_m() !== ex) begin
      bad++;
      $display("FAIL post_reset_lui: valid=%b got %h want %h", m_out_valid, obs_m(), ex);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    dec_t ex;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h700 + 32'(4 * i); in_instr = gen_instr();
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_valid = 1'b1; in_pc = 32'h800 + 32'(4 * i); in_instr = gen_instr();
      ex = ref_dec(mq[0].pc, mq[0].ins, 1'b1);
      total++;
      if (msk(obs_m(), ex.ill) !== msk(ex, ex.ill)) begin
        bad++;
        $display("FAIL stream_head%0d: got %h want %h", i, obs_m(), ex);
      end
      tick();
      total++;
      if (m_count !== 3'd3) begin
        bad++;
        $display("FAIL stream_count%0d: count=%0d want 3", i, m_count);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex = ref_dec(mq[0].pc, mq[0].ins, 1'b1);
      total++;
      if (msk(obs_m(), ex.ill) !== msk(ex, ex.ill)) begin
        bad++;
        $display("FAIL stream_drain%0d: got %h want %h", i, obs_m(), ex);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    dec_t ex_m, ex_n;
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      in_instr  = gen_instr();
      total++;
      if (m_count !== 3'(mq.size()) || n_count !== 3'(mq.size()) ||
          m_out_valid !== (mq.size() != 0) || m_in_ready !== (mq.size() < DEPTH)) begin
        bad++;
        $display("FAIL rand_ctrl%0d: count=%0d/%0d valid=%b ready=%b want count %0d",
                 i, m_count, n_count, m_out_valid, m_in_ready, mq.size());
      end
      if (mq.size() != 0) begin
        ex_m = ref_dec(mq[0].pc, mq[0].ins, 1'b1);
        ex_n = ref_dec(mq[0].pc, mq[0].ins, 1'b0);
        total++;
        if (msk(obs_m(), ex_m.ill) !== msk(ex_m, ex_m.ill)) begin
          bad++;
          $display("FAIL rand_head_m%0d: got %h want %h", i, obs_m(), ex_m);
        end
        total++;
        if (msk(obs_n(), ex_n.ill) !== msk(ex_n, ex_n.ill)) begin
          bad++;
          $display("FAIL rand_head_nm%0d: got %h want %h", i, obs_n(), ex_n);
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fill();
    test_muldiv();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/PC/immediate width (32 or 64).
REQ-002 SHALL have parameter DEPTH, default 4, decoded-entry queue depth (power of two, 2..16).
REQ-003 SHALL have parameter EN_M, default 1, enables RV32M decode (0: M encodings are illegal).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, fetch offers an instruction.
REQ-007 SHALL have port in_ready, output, 1, queue accepts this cycle.
REQ-008 SHALL have port in_pc, input, XLEN, PC of offered instruction.
REQ-009 SHALL have port in_instr, input, 32, raw instruction word.
REQ-010 SHALL have port flush, input, 1, discard all queued entries.
REQ-011 SHALL have port out_valid, output, 1, head entry valid.
REQ-012 SHALL have port out_ready, input, 1, consumer takes head entry.
REQ-013 SHALL have ports out_pc (XLEN), out_rd/out_rs1/out_rs2 (5 each), out_imm (XLEN), out_funct3 (3), out_alt (1, instr[30]), all outputs, head-entry fields.
REQ-014 SHALL have port out_class, output, 4, operation class of head entry.
REQ-015 SHALL have port out_illegal, output, 1, head entry is illegal.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1, entries held.

Function
REQ-017 SHALL decode combinationally at enqueue and store the decoded record, never the raw word.
REQ-018 SHALL encode out_class: 0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 MULDIV, 10 SYSTEM, 11 FENCE, 15 ILLEGAL.
REQ-019 SHALL zero rd for S/B types; zero rs1 for U/J types; zero rs2 for I/U/J types.
REQ-020 SHALL sign-extend I/S/B/J immediates from instr[31] to XLEN; U immediate = instr[31:12]<<12, sign-extended; R-type imm = 0.
REQ-021 SHALL flag illegal (class 15, out_illegal=1): unknown opcode; R-type funct7 not 0000000, not 0100000 (only with funct3 000/101), not 0000001 (only with EN_M=1); shift-immediate with bad funct7; load funct3 011/110/111; store funct3 >= 011; branch funct3 010/011.
REQ-022 SHALL enqueue illegal entries like legal ones (exception raised downstream).
REQ-023 SHALL drive in_ready = (count < DEPTH); no same-cycle bypass when full.
REQ-024 SHALL push when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-025 SHALL keep count unchanged on simultaneous push and pop.
REQ-026 SHALL give latency 1: instruction accepted at edge N is visible with out_valid=1 after edge N, if queue was empty.
REQ-027 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-028 SHALL preserve FIFO order; read/write pointers wrap modulo DEPTH.
REQ-029 SHALL, on flush, set count=0, out_valid=0 at next edge; flush dominates a same-cycle push and pop (both discarded).
REQ-030 SHALL accept a new push in the cycle after flush.
REQ-031 SHALL drive out_valid = (count != 0).

Reset
REQ-032 SHALL, on rstn low, asynchronously clear pointers, count, out_valid, and all out_* fields to 0; in_ready = 1 after reset.
REQ-033 SHALL discard in-flight entries on reset mid-operation; no partial entry survives.
REQ-034 SHALL resume accepting on the first rising clk edge after rstn deasserts.

Verification
REQ-035 SHALL test: push 0xFFF00093 (addi x1,x0,-1), pc 0x100 -> next cycle out_valid=1, class 1, rd 1, rs1 0, rs2 0, imm 0xFFFFFFFF, pc 0x100.
REQ-036 SHALL test: DEPTH=4, out_ready=0, in_valid=1 for 6 cycles -> in_ready 0 after 4th accept, count=4; release out_ready -> 4 entries popped in order, no loss/duplicate.
REQ-037 SHALL test: 0x022081B3 (mul x3,x1,x2) -> EN_M=1 class 9; EN_M=0 class 15, out_illegal=1; 0x402081B3 -> class 0, out_alt=1.
REQ-038 SHALL test: 3 entries queued, flush with simultaneous in_valid and out_ready -> count 0, out_valid 0 next cycle, pushed word absent.
REQ-039 SHALL test: rstn pulled low mid-stream asynchronously (between edges) -> outputs 0 immediately, count 0; post-reset push of 0x00000037 (lui x0,0) yields class 7, imm 0.
REQ-040 SHALL test: continuous push and pop at full rate for 3*DEPTH entries -> count constant, pointers wrap, order preserved.
